// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder: size codes,
// FSM states, byte-enable generation, store lane placement and load extraction.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Half accesses use lane pair addr[1]; bit 0 is ignored (aligned down).
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SZ_BYTE: return 4'b0001 << addr;
            SZ_HALF: return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] addr, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{addr, 3'b000} +: 8];
        h = rdata[{addr[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: return uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr[0];
            default: return |addr;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Word-organised synchronous RAM built from four byte-wide banks, giving a
// per-byte write enable and a registered read that only updates when enabled.
module dmem_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH_WORDS];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we[gi]) begin
                    mem_q[addr] <= wdata[gi*8 +: 8];
                end
                rd_q <= mem_q[addr];
            end
        end

        assign rdata[gi*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with programmable wait states in front of a byte-enabled RAM.
// Optional build macro DMEM_ALIGN_CHECK_EN turns misaligned accesses into errors.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    import dmem_pkg::*;

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          enter_resp;
    logic          acc_bad;
    logic          rsp_bad;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;
    logic          unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign acc_bad = misaligned(size_d, addr_d[1:0]);
    assign rsp_bad = misaligned(size_q, addr_q[1:0]);
`else
    assign acc_bad = 1'b0;
    assign rsp_bad = 1'b0;
`endif

    // The RAM is touched only on the edge that enters RESP, so a held response never rewrites.
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign ram_en     = enter_resp && rst;
    assign ram_we     = (we_d && !acc_bad) ? byte_enable(size_d, addr_d[1:0]) : 4'b0000;

    dmem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_d[AW+1:2]),
        .wdata (store_lanes(size_d, wdata_d)),
        .rdata (ram_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && rsp_bad;
    assign rsp_rdata = (rsp_valid && !we_q && !rsp_bad)
                     ? load_extract(ram_rdata, size_q, addr_q[1:0], uns_q) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder; expectations come from a
// byte-arithmetic memory model and fixed values. Honours DMEM_ALIGN_CHECK_EN.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_asserts = 0;
    int n_fails   = 0;
    int n_txn     = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_known [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_bad(input logic [1:0] size, input logic [31:0] addr);
`ifdef DMEM_ALIGN_CHECK_EN
        if (size == 2'd1) return (addr % 2) != 0;
        if (size >= 2'd2) return (addr % 4) != 0;
`endif
        return 1'b0;
    endfunction

    function automatic int lane_base(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return int'(addr % 4);
        if (size == 2'd1) return int'((addr % 4) / 2 * 2);
        return 0;
    endfunction

    function automatic int lane_count(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr);
        logic [31:0] v;
        int base, n;
        base = lane_base(size, addr);
        n    = lane_count(size);
        if (n == 4) return word;
        v = (word >> (8 * base)) % (32'd1 << (8 * n));
        if (!uns && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] size,
                                                input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] w;
        int base, n;
        w    = word;
        base = lane_base(size, addr);
        n    = lane_count(size);
        for (int b = 0; b < n; b++) begin
            w = w - (((w >> (8 * (base + b))) % 256) << (8 * (base + b)));
            w = w + (((wdata >> (8 * b)) % 256) << (8 * (base + b)));
        end
        return w;
    endfunction

    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       output logic [31:0] rdata, output logic err);
        int          idx, lat, w;
        logic [31:0] exp_rdata;
        logic        exp_err;
        bit          known;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_we = ~we; req_size = 2'($urandom);

        idx       = int'((addr >> 2) % DEPTH);
        exp_err   = model_bad(size, addr);
        known     = we || exp_err || model_known[idx];
        exp_rdata = (we || exp_err) ? 32'd0 : model_load(model_mem[idx], size, uns, addr);

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        check("latency", 32'(lat), 32'(WS + 1));
        rdata = rsp_rdata;
        err   = rsp_err;
        if (known) check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});

        for (int h = 0; h < hold; h++) begin
            req_valid = (h == 1);
            req_addr  = $urandom;
            @(negedge clk);
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            if (known) check("hold_rsp_rdata", rsp_rdata, exp_rdata);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("idle_after_handshake", {30'd0, rsp_valid, req_ready}, 32'd1);

        if (we && !exp_err) begin
            model_mem[idx] = model_store(model_mem[idx], size, addr, wdata);
            if (size >= 2'd2) model_known[idx] = 1'b1;
        end
        n_txn++;
        $display("txn %0d: %s size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 n_txn, we ? "ST" : "LD", size, uns, addr, wdata, rdata, err, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        // Reset state, sampled while reset is held.
        #2;
        check("reset_outputs", {req_ready, rsp_valid, rsp_err, 29'd0}, 32'h8000_0000);
        check("reset_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Word store/load and sub-word extraction.
        txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check("sw_rdata_zero", rd, 32'd0);
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, rd, er);
        check("lw_10", rd, 32'hDEADBEEF);
        check("lw_10_err", {31'd0, er}, 32'd0);
        txn(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 0, rd, er);
        check("lb_13", rd, 32'hFFFFFFDE);
        txn(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0, rd, er);
        check("lbu_13", rd, 32'h000000DE);
        txn(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 0, rd, er);
        check("lh_12", rd, 32'hFFFFDEAD);
        txn(1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 0, rd, er);
        check("lhu_10", rd, 32'h0000BEEF);

        // Byte store into lane 1, then a held response.
        txn(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF5A, 0, rd, er);
        txn(1'b0, 2'd2, 1'b1, 32'h10, 32'd0, 5, rd, er);
        check("lw_after_sb", rd, 32'hDEAD5AEF);

        // Upper address bits ignored: 0x1000 aliases 0x0000.
        txn(1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678, 0, rd, er);
        txn(1'b0, 2'd2, 1'b0, 32'h0000, 32'd0, 0, rd, er);
        check("wrap_lw_0", rd, 32'h12345678);

        // Reset during WAIT drops the store.
        txn(1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5A5A5, 0, rd, er);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("in_wait_req_ready", {31'd0, req_ready}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {req_ready, rsp_valid, rsp_err, 29'd0}, 32'h8000_0000);
        check("async_reset_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        txn(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, rd, er);
        check("lw_20_after_abort", rd, 32'hA5A5A5A5);

`ifdef DMEM_ALIGN_CHECK_EN
        txn(1'b1, 2'd2, 1'b0, 32'h22, 32'h0BADF00D, 0, rd, er);
        check("sw_22_err", {31'd0, er}, 32'd1);
        txn(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, rd, er);
        check("lw_20_after_misaligned", rd, 32'hA5A5A5A5);
`endif

        // Randomized accesses in a prefilled region, with aliasing upper bits.
        for (int i = 0; i < 16; i++) begin
            txn(1'b1, 2'd2, 1'b0, 32'h200 + 32'(4 * i), $urandom, 0, rd, er);
        end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = 32'h200 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 15)) << 12);
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, int'($urandom_range(0, 2)), rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
